// File: rtl/bus_pkg.sv
// Shared types for the 8088 bus-cycle tracker: FSM states, transaction record
// and the chip-select decode helper.
package bus_pkg;

   localparam int unsigned ADDR_W     = 20;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned ADDR_IDX_W = $clog2(ADDR_W);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      STROBE_RD,
      STROBE_WR,
      PUSH
   } state_t;

   typedef enum logic [1:0] {
      KIND_MEM_RD = 2'b00,
      KIND_MEM_WR = 2'b01,
      KIND_IO_RD  = 2'b10,
      KIND_IO_WR  = 2'b11
   } txn_kind_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      txn_kind_t         kind;
   } txn_rec_t;

   // {io_hi, io_lo, mem_hi, mem_lo} for a latched address and cycle type
   function automatic logic [3:0] cs_decode(input logic [ADDR_W-1:0] a,
                                            input logic              iom,
                                            input int unsigned       mem_bit,
                                            input int unsigned       io_bit);
      logic mem_hi;
      logic io_hi;
      mem_hi = a[ADDR_IDX_W'(mem_bit)];
      io_hi  = a[ADDR_IDX_W'(io_bit)];
      return {iom & io_hi, iom & ~io_hi, ~iom & mem_hi, ~iom & ~mem_hi};
   endfunction

endpackage

// File: rtl/bus_cycle_tracker_if.sv
// Processor-pin and transaction-consumer signals of the bus-cycle tracker.
interface bus_cycle_tracker_if;
   import bus_pkg::*;

   logic              ALE;
   logic              IOM;
   logic              RD_n;
   logic              WR_n;
   logic [11:0]       A;
   logic [7:0]        AD;
   logic [ADDR_W-1:0] Address;
   logic [3:0]        cs;
   logic              txn_valid;
   logic              txn_ready;
   logic [ADDR_W-1:0] txn_addr;
   logic [DATA_W-1:0] txn_data;
   logic [1:0]        txn_kind;
   logic              overflow;

   modport master (
      output ALE, IOM, RD_n, WR_n, A, AD, txn_ready,
      input  Address, cs, txn_valid, txn_addr, txn_data, txn_kind, overflow
   );

   modport slave (
      input  ALE, IOM, RD_n, WR_n, A, AD, txn_ready,
      output Address, cs, txn_valid, txn_addr, txn_data, txn_kind, overflow
   );

endinterface

// File: rtl/txn_fifo.sv
// Show-ahead FIFO of transaction records; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module txn_fifo
   import bus_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter type         elem_t = txn_rec_t
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   push,
   input  elem_t                  din,
   output logic                   full,
   input  logic                   pop,
   output elem_t                  dout,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   elem_t              mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt_q;
   logic               do_push;
   logic               do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign count   = cnt_q;
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/bus_cycle_tracker.sv
// Latches the 8088 multiplexed address, decodes chip selects and records each
// completed read/write into a FIFO for a ready/valid consumer.
module bus_cycle_tracker
   import bus_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned MEM_SEL_BIT = 19,
   parameter int unsigned IO_SEL_BIT  = 15
) (
   input  logic                CLK,
   input  logic                RESET,
   bus_cycle_tracker_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic              iom_q;
   logic [3:0]        cs_q;
   logic [DATA_W-1:0] data_q;
   txn_kind_t         kind_q;
   logic              overflow_q;

   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop_ok;
   logic [CNT_W-1:0]  fifo_count;
   txn_rec_t          push_rec;
   txn_rec_t          head;

   assign fifo_push   = (state == PUSH);
   assign fifo_pop_ok = bus.txn_ready & ~fifo_empty;
   assign push_rec    = '{addr: addr_q, data: data_q, kind: kind_q};

   // Address/IOM latch, chip-select decode and the per-cycle FSM
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         addr_q     <= '0;
         iom_q      <= 1'b0;
         cs_q       <= '0;
         data_q     <= '0;
         kind_q     <= KIND_MEM_RD;
         overflow_q <= 1'b0;
      end else begin
         if (bus.ALE) begin
            addr_q <= {bus.A, bus.AD};
            iom_q  <= bus.IOM;
            cs_q   <= cs_decode({bus.A, bus.AD}, bus.IOM, MEM_SEL_BIT, IO_SEL_BIT);
         end else if (state == PUSH) begin
            cs_q <= '0;
         end

         if (fifo_push && fifo_full && !fifo_pop_ok) begin
            overflow_q <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.ALE) state <= ADDR;
            end
            // Both strobes low is a protocol error and is recorded as a write
            ADDR: begin
               if (!bus.WR_n) begin
                  state  <= STROBE_WR;
                  data_q <= bus.AD;
                  kind_q <= iom_q ? KIND_IO_WR : KIND_MEM_WR;
               end else if (!bus.RD_n) begin
                  state  <= STROBE_RD;
                  data_q <= bus.AD;
                  kind_q <= iom_q ? KIND_IO_RD : KIND_MEM_RD;
               end
            end
            STROBE_RD: begin
               if (!bus.RD_n) data_q <= bus.AD;
               else           state  <= PUSH;
            end
            STROBE_WR: begin
               if (!bus.WR_n) data_q <= bus.AD;
               else           state  <= PUSH;
            end
            PUSH: begin
               state <= bus.ALE ? ADDR : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   txn_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .elem_t (txn_rec_t)
   ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (fifo_push),
      .din   (push_rec),
      .full  (fifo_full),
      .pop   (bus.txn_ready),
      .dout  (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.Address   = addr_q;
   assign bus.cs        = cs_q;
   assign bus.overflow  = overflow_q;
   assign bus.txn_valid = (fifo_count != '0);
   assign bus.txn_addr  = head.addr;
   assign bus.txn_data  = head.data;
   assign bus.txn_kind  = 2'(head.kind);

endmodule

// File: tb/tb_bus_cycle_tracker.sv
// Directed bench for bus_cycle_tracker: a queue-based transaction model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_bus_cycle_tracker;
   import bus_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic CLK;
   logic RESET;

   bus_cycle_tracker_if bif();

   bus_cycle_tracker #(
      .FIFO_DEPTH  (DEPTH),
      .MEM_SEL_BIT (19),
      .IO_SEL_BIT  (15)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bif)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int          errors;
   int          checks;
   txn_rec_t    exp_q[$];
   logic        exp_ovf;
   logic [19:0] exp_addr;
   logic [3:0]  exp_cs;
   int          push_req;
   int          push_done;
   txn_rec_t    pend_rec;
   logic [19:0] bp_addr [5];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endfunction

   function automatic logic [3:0] model_cs(input bit iom, input logic [19:0] a);
      if (iom) return a[15] ? 4'b1000 : 4'b0100;
      else     return a[19] ? 4'b0010 : 4'b0001;
   endfunction

   function automatic txn_rec_t mk_rec(input bit iom, input bit wr, input logic [19:0] a, input logic [7:0] d);
      txn_rec_t r;
      r.addr = a;
      r.data = d;
      r.kind = txn_kind_t'({iom, wr});
      return r;
   endfunction

   task automatic drive_ale(input bit iom, input logic [19:0] a, input bit with_push);
      @(negedge CLK);
      bif.ALE = 1'b1;
      bif.IOM = iom;
      bif.A   = a[19:8];
      bif.AD  = a[7:0];
      if (with_push) push_req++;
      @(posedge CLK);
      exp_addr = a;
      exp_cs   = model_cs(iom, a);
   endtask

   task automatic drive_strobe(input bit wr, input int n_low, input logic [7:0] d_mid, input logic [7:0] d_last);
      for (int i = 0; i < n_low; i++) begin
         @(negedge CLK);
         bif.ALE = 1'b0;
         if (wr) bif.WR_n = 1'b0;
         else    bif.RD_n = 1'b0;
         bif.AD = (i == n_low - 1) ? d_last : d_mid;
         @(posedge CLK);
      end
      @(negedge CLK);
      bif.RD_n = 1'b1;
      bif.WR_n = 1'b1;
      bif.AD   = 8'hEE;
      @(posedge CLK);
   endtask

   task automatic end_cycle(input bit pop_too);
      @(negedge CLK);
      bif.ALE = 1'b0;
      push_req++;
      if (pop_too) bif.txn_ready = 1'b1;
      @(posedge CLK);
      exp_cs = 4'b0;
      if (pop_too) begin
         @(negedge CLK);
         bif.txn_ready = 1'b0;
      end
   endtask

   task automatic bus_cycle(input bit iom, input bit wr, input logic [19:0] a, input int n_low,
                            input logic [7:0] d_mid, input logic [7:0] d_last);
      drive_ale(iom, a, 1'b0);
      drive_strobe(wr, n_low, d_mid, d_last);
      pend_rec = mk_rec(iom, wr, a, d_last);
      end_cycle(1'b0);
   endtask

   task automatic drain(input int exp_pops, input string name);
      int pops;
      pops = 0;
      @(negedge CLK);
      bif.txn_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (bif.txn_valid) pops++;
         @(negedge CLK);
      end
      bif.txn_ready = 1'b0;
      chk({name, "_pops"}, 32'(pops), 32'(exp_pops));
      chk({name, "_empty"}, 32'(bif.txn_valid), 32'd0);
   endtask

   task automatic pulse_reset();
      @(posedge CLK);
      #2;
      RESET    = 1'b1;
      exp_addr = '0;
      exp_cs   = '0;
      @(posedge CLK);
      #2;
      RESET = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      RESET = 1'b1;
      bif.ALE = 1'b0;
      bif.IOM = 1'b0;
      bif.RD_n = 1'b1;
      bif.WR_n = 1'b1;
      bif.A = '0;
      bif.AD = '0;
      bif.txn_ready = 1'b0;
      exp_ovf = 1'b0;
      exp_addr = '0;
      exp_cs = '0;
      push_req = 0;
      push_done = 0;
      pend_rec = '0;
      bp_addr = '{20'h00100, 20'h80200, 20'h0A300, 20'h0B400, 20'h8C500};

      fork
         // Transaction model: ordered queue with drop-on-full
         forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
               exp_q.delete();
               exp_ovf   = 1'b0;
               push_done = push_req;
            end else begin
               if (exp_q.size() > 0 && bif.txn_ready) void'(exp_q.pop_front());
               if (push_req != push_done) begin
                  push_done++;
                  if (exp_q.size() < DEPTH) exp_q.push_back(pend_rec);
                  else                      exp_ovf = 1'b1;
               end
            end
         end
         // Per-cycle compare against the model
         forever begin
            @(negedge CLK);
            chk("Address", 32'(bif.Address), 32'(exp_addr));
            chk("cs", 32'(bif.cs), 32'(exp_cs));
            chk("overflow", 32'(bif.overflow), 32'(exp_ovf));
            chk("txn_valid", 32'(bif.txn_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
               chk("txn_addr", 32'(bif.txn_addr), 32'(exp_q[0].addr));
               chk("txn_data", 32'(bif.txn_data), 32'(exp_q[0].data));
               chk("txn_kind", 32'(bif.txn_kind), 32'(exp_q[0].kind));
            end
         end
         begin
            #100000;
            $display("FAIL watchdog: simulation exceeded time budget");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset values
      repeat (3) @(negedge CLK);
      chk("rst_valid", 32'(bif.txn_valid), 32'd0);
      chk("rst_cs", 32'(bif.cs), 32'd0);
      chk("rst_address", 32'(bif.Address), 32'd0);
      chk("rst_ovf", 32'(bif.overflow), 32'd0);
      chk("rst_txn_addr", 32'(bif.txn_addr), 32'd0);
      chk("rst_txn_data_kind", 32'({bif.txn_data, bif.txn_kind}), 32'd0);
      @(posedge CLK);
      #2;
      RESET = 1'b0;

      // Memory write to the upper half
      drive_ale(1'b0, 20'h80123, 1'b0);
      #2;
      chk("t1_cs", 32'(bif.cs), 32'h2);
      chk("t1_address", 32'(bif.Address), 32'h80123);
      drive_strobe(1'b1, 2, 8'h5A, 8'h5A);
      pend_rec = mk_rec(1'b0, 1'b1, 20'h80123, 8'h5A);
      end_cycle(1'b0);
      #2;
      chk("t1_valid", 32'(bif.txn_valid), 32'd1);
      chk("t1_addr", 32'(bif.txn_addr), 32'h80123);
      chk("t1_data", 32'(bif.txn_data), 32'h5A);
      chk("t1_kind", 32'(bif.txn_kind), 32'h1);
      chk("t1_cs_idle", 32'(bif.cs), 32'h0);
      drain(1, "t1_drain");

      // I/O read, data taken from the last low edge
      drive_ale(1'b1, 20'h01C04, 1'b0);
      #2;
      chk("t2_cs", 32'(bif.cs), 32'h4);
      drive_strobe(1'b0, 3, 8'h11, 8'hC3);
      pend_rec = mk_rec(1'b1, 1'b0, 20'h01C04, 8'hC3);
      end_cycle(1'b0);
      #2;
      chk("t2_addr", 32'(bif.txn_addr), 32'h01C04);
      chk("t2_data", 32'(bif.txn_data), 32'hC3);
      chk("t2_kind", 32'(bif.txn_kind), 32'h2);
      drain(1, "t2_drain");

      // Backpressure: five cycles into a four-deep FIFO
      for (int i = 0; i < 5; i++) begin
         bus_cycle(bit'(i & 1), bit'((i >> 1) & 1), bp_addr[i], 1, 8'h00, 8'(8'h10 + i));
      end
      #2;
      chk("t3_ovf", 32'(bif.overflow), 32'd1);
      chk("t3_head", 32'(bif.txn_addr), 32'h00100);
      chk("t3_head_data", 32'(bif.txn_data), 32'h10);
      drain(4, "t3_drain");
      chk("t3_ovf_sticky", 32'(bif.overflow), 32'd1);

      // Simultaneous push and pop while full
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         bus_cycle(1'b0, 1'b1, bp_addr[i], 1, 8'h00, 8'(8'h20 + i));
      end
      drive_ale(1'b0, 20'h8F00D, 1'b0);
      drive_strobe(1'b1, 1, 8'hAB, 8'hAB);
      pend_rec = mk_rec(1'b0, 1'b1, 20'h8F00D, 8'hAB);
      end_cycle(1'b1);
      chk("t4_ovf", 32'(bif.overflow), 32'd0);
      chk("t4_head", 32'(bif.txn_addr), 32'h80200);
      chk("t4_valid", 32'(bif.txn_valid), 32'd1);
      drain(4, "t4_drain");

      // Back-to-back cycles: ALE during PUSH
      drive_ale(1'b1, 20'h08A55, 1'b0);
      drive_strobe(1'b1, 1, 8'h3C, 8'h3C);
      pend_rec = mk_rec(1'b1, 1'b1, 20'h08A55, 8'h3C);
      drive_ale(1'b0, 20'h00010, 1'b1);
      #2;
      chk("t5_valid", 32'(bif.txn_valid), 32'd1);
      chk("t5_cs", 32'(bif.cs), 32'h1);
      chk("t5_head", 32'(bif.txn_addr), 32'h08A55);
      chk("t5_kind", 32'(bif.txn_kind), 32'h3);
      drive_strobe(1'b0, 2, 8'h98, 8'h99);
      pend_rec = mk_rec(1'b0, 1'b0, 20'h00010, 8'h99);
      end_cycle(1'b0);
      drain(2, "t5_drain");

      // Reset in the middle of a write strobe
      bus_cycle(1'b0, 1'b1, 20'h12345, 1, 8'h66, 8'h66);
      drive_ale(1'b0, 20'hF0F0F, 1'b0);
      @(negedge CLK);
      bif.ALE  = 1'b0;
      bif.WR_n = 1'b0;
      bif.AD   = 8'h44;
      @(posedge CLK);
      #2;
      RESET    = 1'b1;
      exp_addr = '0;
      exp_cs   = '0;
      #1;
      chk("t6_address", 32'(bif.Address), 32'd0);
      chk("t6_cs", 32'(bif.cs), 32'd0);
      chk("t6_valid", 32'(bif.txn_valid), 32'd0);
      chk("t6_txn_addr", 32'(bif.txn_addr), 32'd0);
      @(negedge CLK);
      bif.WR_n = 1'b1;
      @(posedge CLK);
      #2;
      RESET = 1'b0;
      repeat (6) @(negedge CLK);
      chk("t6_idle_valid", 32'(bif.txn_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
